// File: rtl/response_misr_checker.sv
// Response-side signature checker: compacts CUT response words into a MISR
// over a programmed number of handshakes, then compares against a golden value.
module response_misr_checker #(
  parameter int unsigned          WIDTH  = 1,
  parameter int unsigned          MISR_W = 16,
  parameter logic [MISR_W-1:0]    POLY   = 16'h002D,
  parameter logic [MISR_W-1:0]    SEED   = 16'h0000,
  parameter int unsigned          CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_pat,
  input  logic [MISR_W-1:0] golden,
  input  logic              resp_valid,
  input  logic [WIDTH-1:0]  resp_data,
  output logic              resp_ready,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t            state_q;
  logic [MISR_W-1:0] sig_q;
  logic [MISR_W-1:0] golden_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  num_q;
  logic              pass_q;

  logic              accept;
  logic [CNT_W-1:0]  cnt_d;
  logic [MISR_W-1:0] sig_d;

  // One MISR shift: feedback from the MSB, response word folded into the LSBs.
  function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                  input logic [WIDTH-1:0]  data);
    logic [MISR_W-1:0] ext;
    ext = '0;
    ext[WIDTH-1:0] = data;
    return (sig << 1) ^ (sig[MISR_W-1] ? POLY : '0) ^ ext;
  endfunction

  assign accept = resp_valid && (state_q == RUN);
  assign cnt_d  = cnt_q + 1'b1;
  assign sig_d  = misr_step(sig_q, resp_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= SEED;
      golden_q <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      pass_q   <= 1'b0;
    end else if (abort) begin
      // Signature is deliberately kept so a debugger can inspect it after abort.
      state_q <= IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            num_q    <= num_pat;
            golden_q <= golden;
            sig_q    <= SEED;
            cnt_q    <= '0;
            pass_q   <= 1'b0;
            state_q  <= (num_pat != '0) ? RUN : CMP;
          end
        end
        RUN: begin
          if (accept) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            if (cnt_d == num_q) state_q <= CMP;
          end
        end
        CMP: begin
          pass_q  <= (sig_q == golden_q);
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_ready = (state_q == RUN);
  assign busy       = (state_q == RUN) || (state_q == CMP);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign count      = cnt_q;

endmodule
